// File: rtl/idma_r_burst_tracker.sv
// Tracks outstanding AXI read bursts and annotates R beats with first-beat and decouple info.
// Optional macro IDMA_R_LEN_CHECK_EN enables the sticky beat-count vs. AR length check.
module idma_r_burst_tracker #(
  parameter int unsigned NumAxInFlight = 2,
  parameter int unsigned LenWidth      = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                testmode_i,
  input  logic                ar_valid_i,
  output logic                ar_ready_o,
  input  logic [LenWidth-1:0] ar_len_i,
  input  logic                ar_decouple_i,
  output logic                ar_valid_o,
  input  logic                ar_ready_i,
  input  logic                r_valid_i,
  input  logic                r_ready_i,
  input  logic                r_last_i,
  output logic                r_first_o,
  output logic                r_decouple_aw_o,
  output logic                orphan_err_o,
  output logic                len_err_o,
  output logic                busy_o
);

  localparam int unsigned PtrW    = (NumAxInFlight > 1) ? $clog2(NumAxInFlight) : 1;
  localparam int unsigned CntW    = $clog2(NumAxInFlight + 1);
  localparam int unsigned CntBits = LenWidth + 1;
  localparam logic [PtrW-1:0] LastIdx = PtrW'(NumAxInFlight - 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e               state_q, state_d;
  logic [CntBits-1:0]   cnt_q, cnt_d;
  logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]      fill_q, fill_d;
  logic [LenWidth:0]    mem_q [NumAxInFlight];
  logic                 orphan_q, orphan_d;

  logic                 full, empty, push, pop, r_hs;
  logic [LenWidth:0]    head;
  logic [LenWidth-1:0]  head_len;

  logic unused_testmode;
  assign unused_testmode = testmode_i;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastIdx) ? '0 : p + PtrW'(1);
  endfunction

  // Full depends only on registered occupancy, so a pop never frees a slot in the same cycle.
  assign full     = (fill_q == CntW'(NumAxInFlight));
  assign empty    = (fill_q == '0);
  assign ar_valid_o = ar_valid_i & ~full;
  assign ar_ready_o = ar_ready_i & ~full;
  assign push     = ar_valid_i & ar_ready_o;
  assign r_hs     = r_valid_i & r_ready_i;
  assign head     = mem_q[rptr_q];
  assign head_len = head[LenWidth:1];

  assign r_decouple_aw_o = ~empty & head[0];
  assign busy_o          = ~empty | (state_q == BURST);
  assign orphan_err_o    = orphan_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pop       = 1'b0;
    r_first_o = 1'b0;
    orphan_d  = orphan_q;
    if (r_hs && empty) orphan_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        r_first_o = r_valid_i & ~empty;
        if (r_hs && !empty) begin
          if (r_last_i) begin
            pop   = 1'b1;
            cnt_d = '0;
          end else begin
            state_d = BURST;
            cnt_d   = CntBits'(1);
          end
        end
      end
      BURST: begin
        if (r_hs && !empty) begin
          if (r_last_i) begin
            pop     = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CntBits'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
    fill_d = fill_q;
    unique case ({push, pop})
      2'b10:   fill_d = fill_q + CntW'(1);
      2'b01:   fill_d = fill_q - CntW'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      fill_q   <= '0;
      orphan_q <= 1'b0;
      for (int unsigned i = 0; i < NumAxInFlight; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      fill_q   <= fill_d;
      orphan_q <= orphan_d;
      if (push) mem_q[wptr_q] <= {ar_len_i, ar_decouple_i};
    end
  end

`ifdef IDMA_R_LEN_CHECK_EN
  logic len_err_q, len_err_d;

  // cnt_q holds the zero-based index of the current beat, so the last beat must see cnt == len.
  always_comb begin
    len_err_d = len_err_q;
    if (r_hs && !empty) begin
      if (r_last_i) begin
        if (cnt_q != {1'b0, head_len}) len_err_d = 1'b1;
      end else if (cnt_q == {1'b0, head_len}) begin
        len_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) len_err_q <= 1'b0;
    else         len_err_q <= len_err_d;
  end

  assign len_err_o = len_err_q;
`else
  logic unused_head_len;
  assign unused_head_len = ^head_len;
  assign len_err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_idma_r_burst_tracker.sv
// Scoreboard bench for idma_r_burst_tracker: a reference queue of accepted ARs predicts R annotations.
module tb_idma_r_burst_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       testmode;
  logic       ar_valid_i, ar_ready_o, ar_valid_o, ar_ready_i, ar_decouple_i;
  logic [7:0] ar_len_i;
  logic       r_valid_i, r_ready_i, r_last_i;
  logic       r_first_o, r_decouple_aw_o, orphan_err_o, len_err_o, busy_o;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] len;
    logic       dec;
  } ar_t;

  ar_t        mq[$];
  logic [1:0] exp_q[$];
  logic [1:0] obs_q[$];
  logic       m_burst, m_orphan, m_lenerr;
  logic [8:0] m_cnt;

  always #5 clk = ~clk;

  idma_r_burst_tracker #(.NumAxInFlight(2), .LenWidth(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .testmode_i(testmode),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_len_i(ar_len_i),
    .ar_decouple_i(ar_decouple_i), .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
    .r_valid_i(r_valid_i), .r_ready_i(r_ready_i), .r_last_i(r_last_i),
    .r_first_o(r_first_o), .r_decouple_aw_o(r_decouple_aw_o),
    .orphan_err_o(orphan_err_o), .len_err_o(len_err_o), .busy_o(busy_o)
  );

  task automatic model_clear();
    mq.delete();
    m_burst  = 1'b0;
    m_orphan = 1'b0;
    m_lenerr = 1'b0;
    m_cnt    = '0;
  endtask

  // Offers one AR (called shortly after a rising edge); waits a bounded time for acceptance.
  task automatic ar_push(input logic [7:0] len, input logic dec);
    int n = 0;
    ar_valid_i = 1'b1; ar_ready_i = 1'b1; ar_len_i = len; ar_decouple_i = dec;
    @(negedge clk);
    while (!ar_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL ar_accept_timeout: ar_ready_o=%b required 1", ar_ready_o);
    end else begin
      mq.push_back('{len: len, dec: dec});
    end
    @(posedge clk); #1;
    ar_valid_i = 1'b0;
  endtask

  // Drives one R handshake; records predicted and observed {r_first_o, r_decouple_aw_o}.
  task automatic r_drive(input logic last);
    logic ef, ed;
    r_valid_i = 1'b1; r_ready_i = 1'b1; r_last_i = last;
    ef = !m_burst && (mq.size() > 0);
    ed = (mq.size() > 0) ? mq[0].dec : 1'b0;
    exp_q.push_back({ef, ed});
    @(negedge clk);
    obs_q.push_back({r_first_o, r_decouple_aw_o});
    @(posedge clk);
    if (mq.size() == 0) begin
      m_orphan = 1'b1;
    end else if (last) begin
`ifdef IDMA_R_LEN_CHECK_EN
      if (m_cnt != {1'b0, mq[0].len}) m_lenerr = 1'b1;
`endif
      void'(mq.pop_front());
      m_burst = 1'b0;
      m_cnt   = '0;
    end else begin
`ifdef IDMA_R_LEN_CHECK_EN
      if (m_cnt == {1'b0, mq[0].len}) m_lenerr = 1'b1;
`endif
      m_burst = 1'b1;
      if (m_cnt != '1) m_cnt = m_cnt + 9'd1;
    end
    #1;
    r_valid_i = 1'b0; r_last_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; testmode = 1'b0;
    ar_valid_i = 1'b1; ar_ready_i = 1'b1; ar_len_i = 8'd0; ar_decouple_i = 1'b0;
    r_valid_i = 1'b1; r_ready_i = 1'b1; r_last_i = 1'b0;
    model_clear();
    #3;
    checks++; if ({ar_valid_o, ar_ready_o} !== 2'b11) begin failures++;
      $display("FAIL reset_ar_pass: got %b required 11", {ar_valid_o, ar_ready_o}); end
    checks++; if ({r_first_o, r_decouple_aw_o, busy_o} !== 3'b000) begin failures++;
      $display("FAIL reset_r_outs: got %b required 000", {r_first_o, r_decouple_aw_o, busy_o}); end
    checks++; if ({orphan_err_o, len_err_o} !== 2'b00) begin failures++;
      $display("FAIL reset_errs: got %b required 00", {orphan_err_o, len_err_o}); end
    ar_valid_i = 1'b0; r_valid_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_burst();
    logic [1:0] e, o;
    ar_push(8'd3, 1'b0);
    checks++; if (busy_o !== 1'b1) begin failures++;
      $display("FAIL single_busy_pending: got %b required 1", busy_o); end
    for (int i = 0; i < 4; i++) r_drive(i == 3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++;
        $display("FAIL single_beat {first,dec}: got %b required %b", o, e); end
    end
    checks++; if (busy_o !== 1'b0) begin failures++;
      $display("FAIL single_busy_done: got %b required 0", busy_o); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] e, o;
    ar_push(8'd1, 1'b0);
    ar_push(8'd0, 1'b1);
    ar_valid_i = 1'b1; ar_len_i = 8'd2; ar_decouple_i = 1'b0;
    #2;
    checks++; if ({ar_ready_o, ar_valid_o} !== 2'b00) begin failures++;
      $display("FAIL b2b_blocked: got %b required 00", {ar_ready_o, ar_valid_o}); end
    r_drive(1'b0);
    #2;
    checks++; if ({ar_ready_o, ar_valid_o} !== 2'b00) begin failures++;
      $display("FAIL b2b_still_blocked: got %b required 00", {ar_ready_o, ar_valid_o}); end
    r_drive(1'b1);
    @(negedge clk);
    checks++; if ({ar_ready_o, ar_valid_o} !== 2'b11) begin failures++;
      $display("FAIL b2b_unblocked: got %b required 11", {ar_ready_o, ar_valid_o}); end
    mq.push_back('{len: 8'd2, dec: 1'b0});
    @(posedge clk); #1;
    ar_valid_i = 1'b0;
    r_drive(1'b1);
    for (int i = 0; i < 3; i++) r_drive(i == 2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++;
        $display("FAIL b2b_beat {first,dec}: got %b required %b", o, e); end
    end
    checks++; if (busy_o !== 1'b0) begin failures++;
      $display("FAIL b2b_busy_done: got %b required 0", busy_o); end
  endtask

  task automatic test_decouple();
    logic [1:0] e, o;
    ar_push(8'd0, 1'b1);
    ar_push(8'd1, 1'b0);
    r_drive(1'b1);
    r_drive(1'b0);
    r_drive(1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++;
        $display("FAIL decouple_beat {first,dec}: got %b required %b", o, e); end
    end
  endtask

  task automatic test_push_pop();
    logic [1:0] e, o;
    ar_push(8'd0, 1'b0);
    ar_valid_i = 1'b1; ar_ready_i = 1'b1; ar_len_i = 8'd0; ar_decouple_i = 1'b1;
    r_drive(1'b1);
    mq.push_back('{len: 8'd0, dec: 1'b1});
    ar_valid_i = 1'b0;
    checks++; if ({busy_o, r_decouple_aw_o} !== 2'b11) begin failures++;
      $display("FAIL pushpop_occupancy {busy,dec}: got %b required 11", {busy_o, r_decouple_aw_o}); end
    r_drive(1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++;
        $display("FAIL pushpop_beat {first,dec}: got %b required %b", o, e); end
    end
    checks++; if (busy_o !== 1'b0) begin failures++;
      $display("FAIL pushpop_busy_done: got %b required 0", busy_o); end
  endtask

  task automatic test_len_check();
    logic [1:0] e, o;
    ar_push(8'd3, 1'b0);
    r_drive(1'b0);
    r_drive(1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++;
        $display("FAIL lencheck_beat {first,dec}: got %b required %b", o, e); end
    end
    checks++; if (len_err_o !== m_lenerr) begin failures++;
      $display("FAIL len_err: got %b required %b", len_err_o, m_lenerr); end
    checks++; if (busy_o !== 1'b0) begin failures++;
      $display("FAIL lencheck_popped busy: got %b required 0", busy_o); end
  endtask

  task automatic test_orphan();
    logic [1:0] e, o;
    checks++; if (orphan_err_o !== 1'b0) begin failures++;
      $display("FAIL orphan_pre: got %b required 0", orphan_err_o); end
    r_drive(1'b1);
    e = exp_q.pop_front(); o = obs_q.pop_front();
    checks++; if (o !== e) begin failures++;
      $display("FAIL orphan_beat {first,dec}: got %b required %b", o, e); end
    checks++; if (orphan_err_o !== m_orphan) begin failures++;
      $display("FAIL orphan_set: got %b required %b", orphan_err_o, m_orphan); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({orphan_err_o, busy_o} !== 2'b10) begin failures++;
      $display("FAIL orphan_sticky {orphan,busy}: got %b required 10", {orphan_err_o, busy_o}); end
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0] e, o;
    ar_push(8'd3, 1'b1);
    r_drive(1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++;
        $display("FAIL midrst_beat1 {first,dec}: got %b required %b", o, e); end
    end
    r_valid_i = 1'b1; r_ready_i = 1'b1; ar_ready_i = 1'b1; ar_valid_i = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({r_first_o, r_decouple_aw_o, busy_o, orphan_err_o, len_err_o} !== 5'b00000) begin
      failures++;
      $display("FAIL midrst_outs {first,dec,busy,orphan,lenerr}: got %b required 00000",
               {r_first_o, r_decouple_aw_o, busy_o, orphan_err_o, len_err_o}); end
    checks++; if ({ar_valid_o, ar_ready_o} !== 2'b11) begin failures++;
      $display("FAIL midrst_ar_pass: got %b required 11", {ar_valid_o, ar_ready_o}); end
    r_valid_i = 1'b0; ar_valid_i = 1'b0;
    model_clear();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    ar_push(8'd1, 1'b1);
    r_drive(1'b0);
    r_drive(1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++;
        $display("FAIL midrst_after {first,dec}: got %b required %b", o, e); end
    end
    checks++; if ({busy_o, orphan_err_o, len_err_o} !== 3'b000) begin failures++;
      $display("FAIL midrst_final {busy,orphan,lenerr}: got %b required 000",
               {busy_o, orphan_err_o, len_err_o}); end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_back_to_back();
    test_decouple();
    test_push_pop();
    test_len_check();
    test_orphan();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/idma_r_burst_tracker.md
IDMA_R_BURST_TRACKER -- requirements
Module: idma_r_burst_tracker

Interface
REQ-001 Parameter NumAxInFlight, default 2: max outstanding read bursts tracked; SHALL be >= 1.
REQ-002 Parameter LenWidth, default 8: width of the AXI burst length field.
REQ-003 clk_i  in  1  single clock; all state SHALL be sampled on its rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 testmode_i  in  1  test mode, passed to internal FIFO.
REQ-006 ar_valid_i / ar_ready_o  in/out  1  upstream AR handshake.
REQ-007 ar_len_i  in  LenWidth  burst length minus one of the offered AR.
REQ-008 ar_decouple_i  in  1  AR belongs to a decoupled request.
REQ-009 ar_valid_o / ar_ready_i  out/in  1  downstream AR handshake toward the manager port.
REQ-010 r_valid_i, r_ready_i, r_last_i  in  1  observed R beat handshake and last flag (monitor only).
REQ-011 r_first_o  out  1  current R beat is the first beat of its burst.
REQ-012 r_decouple_aw_o  out  1  decouple flag of the burst owning the current R beat.
REQ-013 orphan_err_o  out  1  sticky: R handshake seen with no outstanding AR.
REQ-014 len_err_o  out  1  sticky: R burst length mismatch (only with macro, see REQ-030).
REQ-015 busy_o  out  1  bursts outstanding or in progress.

Function
REQ-016 Tracker FIFO of depth NumAxInFlight SHALL store {ar_len_i, ar_decouple_i} per accepted AR.
REQ-017 ar_valid_o = ar_valid_i & !full; ar_ready_o = ar_ready_i & !full; full from registered state only (no same-cycle pop-to-push fall-through).
REQ-018 Push on ar_valid_i & ar_ready_o; AR payload itself is not stored or modified.
REQ-019 FSM states IDLE, BURST; R handshake = r_valid_i & r_ready_i.
REQ-020 IDLE: r_first_o = r_valid_i & !empty; on R handshake with !r_last_i -> BURST, beat counter <= 1.
REQ-021 IDLE: R handshake with r_last_i (single-beat burst) -> pop FIFO, stay IDLE.
REQ-022 BURST: r_first_o = 0; each R handshake increments counter; R handshake with r_last_i -> pop, counter <= 0, -> IDLE.
REQ-023 r_decouple_aw_o = FIFO head decouple bit whenever FIFO non-empty, else 0; combinational, zero latency.
REQ-024 Beat counter LenWidth+1 bits, saturating at all-ones; no wrap-around.
REQ-025 Simultaneous push and pop: both SHALL occur; occupancy unchanged.
REQ-026 R handshake while FIFO empty: orphan_err_o <= 1, FSM and FIFO unchanged, r_first_o = 0.
REQ-027 busy_o = !empty | (state == BURST).
REQ-028 Sticky errors clear only on reset.

Reset
REQ-029 On rst_ni low, asynchronously: FIFO empty, state IDLE, counter 0, orphan_err_o 0, len_err_o 0; hence ar_ready_o = ar_ready_i, ar_valid_o = ar_valid_i, r_first_o 0, busy_o 0; reset mid-burst discards all tracked bursts.

Configuration
REQ-030 Macro IDMA_R_LEN_CHECK_EN defined: on last-beat handshake, if counter != head len, len_err_o <= 1; on non-last handshake with counter == head len, len_err_o <= 1; pop still on r_last_i only.
REQ-031 Macro undefined: length check logic absent, len_err_o tied 0, counter still provided for debug.

Verification
REQ-032 AR len=3 decouple=0 accepted, then 4 R beats, last on 4th -> r_first_o 1 on beat 1 only, r_decouple_aw_o 0, busy_o 0 after last.
REQ-033 NumAxInFlight=2: 3 ARs back-to-back, no R -> third blocked (ar_ready_o 0, ar_valid_o 0) until first burst's last beat, then accepted next cycle.
REQ-034 AR len=0 decouple=1 then AR len=1 decouple=0 -> beat 1 first=1/decouple=1; beat 2 first=1/decouple=0; beat 3 first=0.
REQ-035 R handshake with FIFO empty -> orphan_err_o 1 next cycle, stays 1 until reset.
REQ-036 With IDMA_R_LEN_CHECK_EN: AR len=3, r_last_i on beat 2 -> len_err_o 1, FIFO popped; without macro len_err_o stays 0.
REQ-037 Assert rst_ni mid-burst (beat 2 of 4) -> outputs at reset values immediately; new AR/R sequence after release tracked correctly.
